pair_reader: RTL and testbench



---
 rtl/pair_reader.sv | 136 +++++++++++++
 tb/tb_pair_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pair_reader.sv
// pair_reader: read-side controller for the paired-word register store.
// It strobes re twice per pair, packs the two returned words into one
// 2*WIDTH pair and buffers pairs in a DEPTH-entry FIFO with a valid/ready
// output.
// Ports: clk, rst_n (async active-low), avail, re, rd[WIDTH],
//        out_valid, out_ready, out_data[2*WIDTH], count, busy.
// Macro PAIR_READER_SWAP_EN: when defined, the first word read goes to
// the upper half of the pair; the default puts it in the lower half.
module pair_reader #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     avail,
   output logic                     re,
   input  logic [WIDTH-1:0]         rd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ1 = 2'd1,
      REQ2 = 2'd2,
      CAP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_word0;
   logic [2*WIDTH-1:0]   r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;

   logic                 w_push;
   logic                 w_pop;
   logic [CW-1:0]        w_cap_lvl;
   logic [2*WIDTH-1:0]   w_pair;

   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid && out_ready;
   assign w_push    = (r_state == CAP);
   assign out_data  = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign busy      = (r_state != IDLE);

   // Occupancy as it will stand after this CAP cycle's push and any pop.
   // count is at most DEPTH-1 in CAP, so the sum fits in CW bits.
   assign w_cap_lvl = r_count + CW'(1) - CW'(w_pop);

`ifdef PAIR_READER_SWAP_EN
   assign w_pair = {r_word0, rd};
`else
   assign w_pair = {rd, r_word0};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      re     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (avail && (r_count < CW'(DEPTH))) begin
               w_next = REQ1;
            end
         end
         REQ1: begin
            re     = 1'b1;
            w_next = REQ2;
         end
         REQ2: begin
            re     = 1'b1;
            w_next = CAP;
         end
         CAP: begin
            if (avail && (w_cap_lvl < CW'(DEPTH))) begin
               w_next = REQ1;
            end else begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // rd answers the previous cycle's re, so REQ2 sees the first word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word0 <= '0;
      end else if (r_state == REQ2) begin
         r_word0 <= rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_pair;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_pair_reader.sv
// Scoreboard bench for pair_reader: directed vectors, expected pairs
// queued at stimulus time and popped by a monitor on each handshake.
module tb_pair_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        avail = 1'b0;
   logic        re;
   logic [15:0] rd = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  count;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int re_cnt = 0;
   int re_mark;

   logic [31:0] sb[$];
   logic [15:0] words[$];
   logic        re_seen = 1'b0;

   pair_reader #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .avail(avail),
      .re(re),
      .rd(rd),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .count(count),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pk(input logic [15:0] w0,
                                      input logic [15:0] w1);
`ifdef PAIR_READER_SWAP_EN
      return {w0, w1};
`else
      return {w1, w0};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Store model: one word per re, returned in the following cycle.
   initial begin
      forever begin
         @(negedge clk);
         re_seen = re;
         @(posedge clk);
         #1;
         if (re_seen) begin
            if (words.size() != 0) rd = words.pop_front();
            else rd = 16'hDEAD;
         end
      end
   end

   always @(negedge clk) begin
      if (re) re_cnt++;
   end

   // Monitor: every accepted head pair must match the scoreboard front.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: got %h expected none", out_data);
         end else begin
            chk("pop_data", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      #3;
      chk("rst_re", {31'b0, re}, 32'd0);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // Single pair
      words.push_back(16'hAAAA);
      words.push_back(16'h5555);
      sb.push_back(pk(16'hAAAA, 16'h5555));
      re_mark = re_cnt;
      avail = 1'b1;
      tick(1);
      avail = 1'b0;
      tick(3);
      chk("single_valid", {31'b0, out_valid}, 32'd1);
      chk("single_count", {29'b0, count}, 32'd1);
      chk("single_data", out_data, pk(16'hAAAA, 16'h5555));
      chk("single_re_cycles", re_cnt - re_mark, 32'd2);
      chk("single_busy", {31'b0, busy}, 32'd0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("single_drained", {29'b0, count}, 32'd0);

      // Backpressure fill
      for (int i = 1; i <= 12; i++) words.push_back(16'(i));
      for (int i = 0; i < 4; i++)
         sb.push_back(pk(16'(2*i+1), 16'(2*i+2)));
      re_mark = re_cnt;
      avail = 1'b1;
      tick(20);
      chk("fill_count", {29'b0, count}, 32'd4);
      chk("fill_busy", {31'b0, busy}, 32'd0);
      chk("fill_re", {31'b0, re}, 32'd0);
      chk("fill_re_cycles", re_cnt - re_mark, 32'd8);
      chk("fill_head", out_data, 32'h0002_0001 ^
          (pk(16'h1, 16'h2) ^ pk(16'h1, 16'h2)));

      // Drain with simultaneous push in CAP, wrapping the pointers
      sb.push_back(pk(16'h0009, 16'h000A));
      sb.push_back(pk(16'h000B, 16'h000C));
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("pop_one_count", {29'b0, count}, 32'd3);
      tick(3);
      chk("cap_busy", {31'b0, busy}, 32'd1);
      chk("cap_re", {31'b0, re}, 32'd0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("pushpop_count", {29'b0, count}, 32'd3);

      // avail dropped during REQ1: the pair still completes
      avail = 1'b0;
      chk("drop_in_req1", {31'b0, re}, 32'd1);
      tick(3);
      chk("drop_count", {29'b0, count}, 32'd4);
      chk("drop_busy", {31'b0, busy}, 32'd0);
      re_mark = re_cnt;
      tick(4);
      chk("drop_no_re", re_cnt - re_mark, 32'd0);
      out_ready = 1'b1;
      tick(5);
      out_ready = 1'b0;
      chk("drain_count", {29'b0, count}, 32'd0);
      chk("drain_sb_empty", sb.size(), 32'd0);

      // Reset during REQ2
      words.push_back(16'h1111);
      words.push_back(16'h2222);
      avail = 1'b1;
      tick(2);
      chk("pre_rst_re", {31'b0, re}, 32'd1);
      rst_n = 1'b0;
      avail = 1'b0;
      #1;
      chk("mid_rst_re", {31'b0, re}, 32'd0);
      chk("mid_rst_count", {29'b0, count}, 32'd0);
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      tick(2);
      words.delete();
      rst_n = 1'b1;

      // Empty pop after reset
      out_ready = 1'b1;
      tick(3);
      out_ready = 1'b0;
      chk("empty_count", {29'b0, count}, 32'd0);
      chk("empty_valid", {31'b0, out_valid}, 32'd0);
      chk("empty_data", out_data, 32'd0);

      // Fresh pair after reset
      words.push_back(16'h3333);
      words.push_back(16'h4444);
      sb.push_back(pk(16'h3333, 16'h4444));
      re_mark = re_cnt;
      avail = 1'b1;
      tick(1);
      avail = 1'b0;
      tick(3);
      chk("fresh_data", out_data, pk(16'h3333, 16'h4444));
      chk("fresh_re_cycles", re_cnt - re_mark, 32'd2);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(2);
      chk("final_sb_empty", sb.size(), 32'd0);
      chk("final_count", {29'b0, count}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
